// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared constants, dealer state encoding and card value helper
package card_pkg;
  localparam int DECK_SIZE      = 52;
  localparam int CODE_W         = 6;
  localparam int TOTAL_W        = 6;
  localparam int DEALER_HIT_MAX = 15;
  localparam int BUST_LIMIT     = 21;

  typedef enum logic [3:0] {
    EMPTY, LOADING, READY, DEAL_P0, DEAL_P1, DEAL_D0, DEAL_D1,
    PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DONE
  } state_t;

  // Rank 1..12 from the code; face ranks collapse to 10, aces stay 1.
  function automatic logic [3:0] card_value(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] rank;
    rank = (code % CODE_W'(12)) + CODE_W'(1);
    return (rank > CODE_W'(10)) ? 4'd10 : rank[3:0];
  endfunction
endpackage

// File: rtl/card_deck_mem.sv
// rtl/card_deck_mem.sv - deck register file with write pointer and combinational read
module card_deck_mem
  import card_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              restart,
  input  logic [CODE_W-1:0] wdata,
  input  logic [CODE_W-1:0] rd_ptr,
  output logic [CODE_W-1:0] rdata,
  output logic              wr_last
);
  logic [CODE_W-1:0] mem [DECK_SIZE];
  logic [CODE_W-1:0] wr_ptr;
  logic [CODE_W-1:0] wr_addr;

  // A restarting beat overwrites index 0 regardless of where the pointer was left.
  assign wr_addr = restart ? '0 : wr_ptr;
  assign wr_last = (wr_addr == CODE_W'(DECK_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= wr_last ? '0 : wr_addr + CODE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
  end

  assign rdata = (rd_ptr < CODE_W'(DECK_SIZE)) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - stores a loaded deck and plays one blackjack round per start pulse
module card_dealer
  import card_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [CODE_W-1:0]  load_data,
  output logic               load_err,
  input  logic               start,
  input  logic               hit,
  input  logic               stand,
  output logic               card_strobe,
  output logic [3:0]         card_value,
  output logic               card_to_dealer,
  output logic [TOTAL_W-1:0] player_total,
  output logic [TOTAL_W-1:0] dealer_total,
  output logic               player_turn,
  output logic               round_done,
  output logic               player_bust,
  output logic               dealer_bust,
  output logic               deck_empty
);
  state_t state, next_state;
  logic [CODE_W-1:0]  rd_ptr, rd_code;
  logic [3:0]         cur_val;
  logic               beat, restart, first_beat, bad_code, wr_last, exhausted;
  logic               deal, to_dealer, set_empty, set_dbust, clear_round;
  logic [TOTAL_W-1:0] player_next, dealer_next;

  card_deck_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (beat),
    .restart (restart),
    .wdata   (load_data),
    .rd_ptr  (rd_ptr),
    .rdata   (rd_code),
    .wr_last (wr_last)
  );

  assign load_ready  = state inside {EMPTY, LOADING, READY, DONE};
  assign beat        = load_valid && load_ready;
  assign restart     = beat && (state == READY || state == DONE);
  assign first_beat  = beat && (state != LOADING);
  assign bad_code    = (load_data == '0) || (load_data > CODE_W'(DECK_SIZE));
  assign cur_val     = card_pkg::card_value(rd_code);
  assign exhausted   = (rd_ptr == CODE_W'(DECK_SIZE));
  assign player_next = player_total + TOTAL_W'(cur_val);
  assign dealer_next = dealer_total + TOTAL_W'(cur_val);
  assign player_turn = (state == PLAYER_TURN);
  assign round_done  = (state == DONE);
  assign player_bust = (player_total > TOTAL_W'(BUST_LIMIT));

  always_comb begin
    next_state  = state;
    deal        = 1'b0;
    to_dealer   = 1'b0;
    set_empty   = 1'b0;
    set_dbust   = 1'b0;
    clear_round = 1'b0;
    case (state)
      EMPTY, LOADING: if (beat) next_state = wr_last ? READY : LOADING;
      READY, DONE: begin
        if (beat) begin
          next_state = wr_last ? READY : LOADING;
        end else if (start && !(state == DONE && deck_empty)) begin
          next_state  = DEAL_P0;
          clear_round = 1'b1;
        end
      end
      DEAL_P0: begin deal = 1'b1; next_state = DEAL_P1; end
      DEAL_P1: begin deal = 1'b1; next_state = DEAL_D0; end
      DEAL_D0: begin deal = 1'b1; to_dealer = 1'b1; next_state = DEAL_D1; end
      DEAL_D1: begin deal = 1'b1; to_dealer = 1'b1; next_state = PLAYER_TURN; end
      PLAYER_TURN: begin
        if (stand)    next_state = DEALER_TURN;
        else if (hit) next_state = PLAYER_DRAW;
      end
      PLAYER_DRAW: begin
        deal       = 1'b1;
        next_state = (player_next > TOTAL_W'(BUST_LIMIT)) ? DONE : PLAYER_TURN;
      end
      DEALER_TURN: begin
        if (dealer_total <= TOTAL_W'(DEALER_HIT_MAX)) begin
          deal      = 1'b1;
          to_dealer = 1'b1;
        end else begin
          next_state = DONE;
          set_dbust  = (dealer_total > TOTAL_W'(BUST_LIMIT));
        end
      end
      default: next_state = EMPTY;
    endcase
    // Running out of cards overrides whatever deal was due this cycle.
    if (deal && exhausted) begin
      deal       = 1'b0;
      set_empty  = 1'b1;
      next_state = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EMPTY;
      rd_ptr         <= '0;
      load_err       <= 1'b0;
      card_strobe    <= 1'b0;
      card_value     <= '0;
      card_to_dealer <= 1'b0;
      player_total   <= '0;
      dealer_total   <= '0;
      dealer_bust    <= 1'b0;
      deck_empty     <= 1'b0;
    end else begin
      state       <= next_state;
      card_strobe <= deal;
      if (first_beat)           load_err <= bad_code;
      else if (beat && bad_code) load_err <= 1'b1;
      if (restart || clear_round) begin
        player_total <= '0;
        dealer_total <= '0;
        dealer_bust  <= 1'b0;
      end
      if (restart) begin
        rd_ptr     <= '0;
        deck_empty <= 1'b0;
      end
      if (deal) begin
        card_value     <= cur_val;
        card_to_dealer <= to_dealer;
        rd_ptr         <= rd_ptr + CODE_W'(1);
        if (to_dealer) dealer_total <= dealer_next;
        else           player_total <= player_next;
      end
      if (set_empty) deck_empty  <= 1'b1;
      if (set_dbust) dealer_bust <= 1'b1;
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - randomized bench for card_dealer against a round-level reference model
module tb_card_dealer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [5:0] load_data = '0;
  logic       load_err;
  logic       start = 1'b0, hit = 1'b0, stand = 1'b0;
  logic       card_strobe;
  logic [3:0] card_value;
  logic       card_to_dealer;
  logic [5:0] player_total, dealer_total;
  logic       player_turn, round_done, player_bust, dealer_bust, deck_empty;

  card_dealer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_err(load_err),
    .start(start), .hit(hit), .stand(stand),
    .card_strobe(card_strobe), .card_value(card_value), .card_to_dealer(card_to_dealer),
    .player_total(player_total), .dealer_total(dealer_total),
    .player_turn(player_turn), .round_done(round_done),
    .player_bust(player_bust), .dealer_bust(dealer_bust), .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a deck array with a draw index and the hand totals.
  int deck_buf[52];
  int deck[52];
  int m_ptr, m_pt, m_dt;
  bit m_empty, m_done, m_dbust, m_err;
  int exp_q[$];
  int obs_q[$];
  int obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (card_strobe) begin
      obs_q.push_back(int'(card_value) * 2 + int'(card_to_dealer));
      obs_cyc.push_back(cyc);
    end
  end

  function automatic int val_of(input int code);
    int r;
    r = (code % 12) + 1;
    return (r > 10) ? 10 : r;
  endfunction

  task automatic m_draw(input bit to_d, output bit ok);
    int v;
    if (m_ptr >= 52) begin
      m_empty = 1'b1;
      ok = 1'b0;
    end else begin
      v = val_of(deck[m_ptr]);
      m_ptr++;
      if (to_d) m_dt += v; else m_pt += v;
      exp_q.push_back(v * 2 + int'(to_d));
      ok = 1'b1;
    end
  endtask

  task automatic m_start();
    bit ok;
    if (m_done && m_empty) return;
    m_pt = 0; m_dt = 0; m_dbust = 0; m_done = 0;
    m_draw(0, ok);
    if (ok) m_draw(0, ok);
    if (ok) m_draw(1, ok);
    if (ok) m_draw(1, ok);
    if (!ok) m_done = 1;
  endtask

  task automatic m_hit();
    bit ok;
    m_draw(0, ok);
    if (!ok || m_pt > 21) m_done = 1;
  endtask

  task automatic m_stand();
    bit ok;
    for (int k = 0; k < 60; k++) begin
      if (m_dt <= 15) begin
        m_draw(1, ok);
        if (!ok) begin m_done = 1; return; end
      end else begin
        m_dbust = (m_dt > 21);
        m_done = 1;
        return;
      end
    end
  endtask

  task automatic shuffle_buf();
    int j, t;
    for (int i = 0; i < 52; i++) deck_buf[i] = i + 1;
    for (int i = 51; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = deck_buf[i]; deck_buf[i] = deck_buf[j]; deck_buf[j] = t;
    end
  endtask

  task automatic load_deck(input bit poke_start);
    bit any_bad;
    any_bad = 0;
    obs_q.delete();
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (i == 0) check_eq("load_ready_first", load_ready, 1);
      load_valid = 1'b1;
      load_data  = 6'(deck_buf[i]);
      if (poke_start && i == 20) start = 1'b1;
      if (deck_buf[i] == 0 || deck_buf[i] > 52) any_bad = 1;
      @(negedge clk);
      load_valid = 1'b0;
      start = 1'b0;
      if (i == 0) begin
        check_eq("load_err_first_beat", load_err, int'(deck_buf[0] == 0 || deck_buf[0] > 52));
        check_eq("round_done_on_load", round_done, 0);
        check_eq("deck_empty_on_load", deck_empty, 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 52; i++) deck[i] = deck_buf[i];
    m_ptr = 0; m_pt = 0; m_dt = 0;
    m_empty = 0; m_done = 0; m_dbust = 0; m_err = any_bad;
    @(negedge clk);
    check_eq("load_err_after_load", load_err, int'(m_err));
    check_eq("no_strobe_during_load", obs_q.size(), 0);
    check_eq("ready_after_load", load_ready, 1);
    check_eq("idle_after_load", int'({round_done, player_turn}), 0);
    check_eq("totals_after_load", int'({player_total, dealer_total}), 0);
  endtask

  task automatic compare_round();
    check_eq("n_cards", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq("card", obs_q[i], exp_q[i]);
    check_eq("player_total", player_total, m_pt);
    check_eq("dealer_total", dealer_total, m_dt);
    check_eq("player_bust", player_bust, int'(m_pt > 21));
    check_eq("dealer_bust", dealer_bust, int'(m_dbust));
    check_eq("deck_empty", deck_empty, int'(m_empty));
    check_eq("round_done", round_done, int'(m_done));
    check_eq("player_turn_end", player_turn, 0);
  endtask

  // mode 0: stand at once, 1: hit once then stand, 2: random play, 3: hit+stand together
  task automatic play_round(input int mode);
    int hits, thresh;
    bit finished;
    thresh = $urandom_range(13, 18);
    hits = 0;
    finished = 0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    m_start();
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (round_done) begin finished = 1; break; end
      if (player_turn) begin
        if (mode == 3 || (mode == 2 && $urandom_range(0, 9) == 0)) begin
          hit = 1'b1; stand = 1'b1; m_stand();
        end else if (mode == 0 || (mode == 1 && hits > 0) || (mode == 2 && m_pt >= thresh)) begin
          stand = 1'b1; m_stand();
        end else begin
          hit = 1'b1; hits++; m_hit();
        end
      end
      @(negedge clk);
      hit = 1'b0;
      stand = 1'b0;
    end
    check_eq("round_finished", finished, 1);
    @(negedge clk);
    compare_round();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_outs"}, int'({card_strobe, card_value, card_to_dealer, player_total, dealer_total,
                                   player_turn, round_done, player_bust, dealer_bust, deck_empty, load_err}), 0);
    check_eq({tag, "_ready"}, load_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #23;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed deck with a start poked mid-load
    for (int i = 0; i < 52; i++) deck_buf[i] = $urandom_range(1, 52);
    deck_buf[0] = 10; deck_buf[1] = 9; deck_buf[2] = 5;
    deck_buf[3] = 4;  deck_buf[4] = 3; deck_buf[5] = 2;
    load_deck(1);
    play_round(0);
    check_eq("t1_player_total", player_total, 20);
    check_eq("t1_dealer_total", dealer_total, 18);
    check_eq("t1_n_cards", obs_q.size(), 6);
    if (obs_cyc.size() >= 4) check_eq("t1_deal_back_to_back", obs_cyc[3] - obs_cyc[0], 3);
    else check_eq("t1_deal_back_to_back", obs_cyc.size(), 4);

    // Player bust on a single hit, reloaded from DONE
    for (int i = 0; i < 52; i++) deck_buf[i] = $urandom_range(1, 52);
    deck_buf[0] = 10; deck_buf[1] = 11; deck_buf[2] = 10; deck_buf[3] = 10; deck_buf[4] = 10;
    load_deck(0);
    play_round(1);
    check_eq("t2_player_total", player_total, 30);
    check_eq("t2_player_bust", player_bust, 1);
    check_eq("t2_n_cards", obs_q.size(), 5);

    // Sequential deck played to exhaustion, then a start with no cards left
    for (int i = 0; i < 52; i++) deck_buf[i] = i + 1;
    load_deck(0);
    for (int r = 0; r < 40 && !deck_empty; r++) play_round(2);
    check_eq("t3_deck_empty", deck_empty, 1);
    play_round(2);
    check_eq("t3_noop_cards", obs_q.size(), 0);

    // Random shuffled decks with random play
    repeat (3) begin
      shuffle_buf();
      load_deck(0);
      repeat (4) play_round(2);
    end

    // Hit and stand together
    shuffle_buf();
    load_deck(0);
    play_round(3);

    // Out-of-range codes, then a clean deck clears the flag
    shuffle_buf();
    deck_buf[5] = 0;
    deck_buf[9] = 53;
    load_deck(0);
    check_eq("t5_load_err", load_err, 1);
    play_round(2);
    shuffle_buf();
    load_deck(0);
    check_eq("t5_load_err_cleared", load_err, 0);

    // Asynchronous reset while the dealer is drawing
    for (int i = 0; i < 52; i++) deck_buf[i] = $urandom_range(1, 52);
    deck_buf[0] = 10; deck_buf[1] = 9; deck_buf[2] = 5; deck_buf[3] = 4;
    load_deck(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (player_turn) begin seen = 1; break; end
      @(negedge clk);
    end
    check_eq("t6_player_turn_reached", seen, 1);
    stand = 1'b1;
    @(posedge clk);
    #2 stand = 1'b0;
    rst_n = 1'b0;
    #1 check_idle_outputs("midround_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_done = 0; m_empty = 0; m_pt = 0; m_dt = 0; m_dbust = 0;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_start_in_empty_strobes", obs_q.size(), 0);
    check_idle_outputs("t6_start_in_empty");
    shuffle_buf();
    load_deck(0);
    play_round(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
